// File: rtl/kyber_pkg.sv
// Shared ML-KEM arithmetic package: ring constants, zetas ROM, the Montgomery
// and Barrett reductions, and the transform controller state type.
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;
  localparam int BARRETT_V  = 20159;

  // mont^2/128: undoes the 2^7 growth of the seven GS layers and leaves the
  // result in Montgomery form.
  localparam logic signed [15:0] INVNTT_F = 16'sd1441;

  typedef enum logic [1:0] {
    IDLE,
    COMP,
    SCALE,
    DONE
  } state_e;

  // Powers of the 256th root of unity 17, times 2^16, in bit-reversed order
  // and centred around zero.
  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  // Montgomery product: (a*b) * 2^-16 mod Q, wrapping like C int16.
  function automatic logic signed [15:0] fqmul(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [31:0] p;
    logic signed [31:0] mExt;
    logic signed [31:0] t;
    logic signed [15:0] m;
    p    = {{16{a[15]}}, a} * {{16{b[15]}}, b};
    m    = 16'(p * KYBER_QINV);
    mExt = {{16{m[15]}}, m};
    t    = p - mExt * KYBER_Q;
    return 16'(t >>> 16);
  endfunction

  // Barrett reduction to the centred representative of a mod Q.
  function automatic logic signed [15:0] barrett_reduce(input logic signed [15:0] a);
    logic signed [31:0] x;
    logic signed [31:0] t;
    x = {{16{a[15]}}, a};
    t = ((BARRETT_V * x + 32'sd33554432) >>> 26) * KYBER_Q;
    return 16'(x - t);
  endfunction

endpackage

// File: rtl/gs_butterfly.sv
// Gentleman-Sande butterfly: sum path is Barrett-reduced, difference path is
// twisted by zeta through a Montgomery multiply. Purely combinational.
module gs_butterfly
  import kyber_pkg::*;
(
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  input  logic signed [15:0] zeta_i,
  output logic signed [15:0] sum_o,
  output logic signed [15:0] diff_o
);

  logic signed [15:0] sum16;
  logic signed [15:0] diff16;

  // Both intermediates wrap to 16 bits before reduction, matching C int16.
  always_comb begin
    sum16  = a_i + b_i;
    diff16 = b_i - a_i;
    sum_o  = barrett_reduce(sum16);
    diff_o = fqmul(zeta_i, diff16);
  end

endmodule

// File: rtl/inv_ntt.sv
// Inverse NTT for ML-KEM: seven GS layers at one butterfly per cycle, then a
// 256-cycle scaling pass by INVNTT_F through the same butterfly multiplier.
module inv_ntt
  import kyber_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] r_in  [KYBER_N],
  output logic               done,
  output logic signed [15:0] r_out [KYBER_N]
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [7:0]         len_q;
  logic [6:0]         k_q;
  logic [7:0]         start_q;
  logic [7:0]         j_q;
  logic signed [15:0] r_q [KYBER_N];

  logic [7:0]         idxB;
  logic               lastInGroup, lastGroup, lastLayer, lastScale;
  logic signed [15:0] bfA, bfB, bfZeta, bfSum, bfDiff;

  // Schedule boundary flags derived from the loop counters.
  always_comb begin
    idxB        = j_q + len_q;
    lastInGroup = (j_q == 8'(start_q + len_q - 8'd1));
    lastGroup   = (({1'b0, start_q} + {len_q, 1'b0}) == 9'd256);
    lastLayer   = (len_q == 8'd128);
    lastScale   = (j_q == 8'd255);
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMP;
      COMP:    if (lastInGroup && lastGroup && lastLayer) state_d = SCALE;
      SCALE:   if (lastScale) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: done rises the edge after DONE is reached.
  always_comb begin
    done_d = (state_q == DONE);
  end

  // Butterfly operands; in SCALE a=0 so the difference path yields fqmul(F, r[j]).
  always_comb begin
    bfA    = r_q[j_q];
    bfB    = r_q[idxB];
    bfZeta = 16'(ZETAS[k_q]);
    if (state_q == SCALE) begin
      bfA    = '0;
      bfB    = r_q[j_q];
      bfZeta = INVNTT_F;
    end
  end

  gs_butterfly u_bf (
    .a_i    (bfA),
    .b_i    (bfB),
    .zeta_i (bfZeta),
    .sum_o  (bfSum),
    .diff_o (bfDiff)
  );

  // Register file and loop counters: capture, butterfly write-back, scaling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KYBER_N; i++) r_q[i] <= '0;
      len_q   <= '0;
      k_q     <= '0;
      start_q <= '0;
      j_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            r_q     <= r_in;
            len_q   <= 8'd2;
            k_q     <= 7'd127;
            start_q <= '0;
            j_q     <= '0;
          end
        end
        COMP: begin
          r_q[j_q]  <= bfSum;
          r_q[idxB] <= bfDiff;
          if (lastInGroup) begin
            k_q <= k_q - 7'd1;
            if (lastGroup) begin
              start_q <= '0;
              j_q     <= '0;
              if (!lastLayer) len_q <= len_q << 1;
            end else begin
              start_q <= start_q + (len_q << 1);
              j_q     <= start_q + (len_q << 1);
            end
          end else begin
            j_q <= j_q + 8'd1;
          end
        end
        SCALE: begin
          r_q[j_q] <= bfDiff;
          j_q      <= j_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign done  = done_q;
  assign r_out = r_q;

endmodule

// File: tb/tb_inv_ntt.sv
// Self-checking bench for inv_ntt against a loop-level model of the inverse
// transform built from independently generated twiddle factors.
module tb_inv_ntt;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               done;
  logic signed [15:0] rIn  [256];
  logic signed [15:0] rOut [256];

  int total = 0;
  int bad   = 0;

  int zetaTab  [128];
  int modelIn  [256];
  int modelOut [256];

  typedef struct {
    int kind;
    int param;
    int expR0Mod;
    int othersZero;
  } tv_t;

  tv_t tvTable [7];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  inv_ntt dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .r_in  (rIn),
    .done  (done),
    .r_out (rOut)
  );

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wrap16(longint x);
    longint y;
    y = x & 64'hFFFF;
    if (y >= 32768) y = y - 65536;
    return int'(y);
  endfunction

  function automatic int fqmulRef(longint a, longint b);
    longint p;
    longint m;
    p = a * b;
    m = wrap16(p * -3327);
    return wrap16((p - m * 3329) >>> 16);
  endfunction

  function automatic int barrettRef(longint a);
    longint t;
    t = ((20159 * a + 33554432) >>> 26) * 3329;
    return wrap16(a - t);
  endfunction

  function automatic int modq(int v);
    int r;
    r = v % 3329;
    if (r < 0) r = r + 3329;
    return r;
  endfunction

  function automatic int countMismatch();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if (int'($signed(rOut[i])) != modelOut[i]) n++;
    return n;
  endfunction

  function automatic int countOutOfRange();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if (int'($signed(rOut[i])) >= 3329 || int'($signed(rOut[i])) <= -3329) n++;
    return n;
  endfunction

  function automatic int countNonZero();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if (rOut[i] != 16'sd0) n++;
    return n;
  endfunction

  // zeta[i] = 2^16 * 17^bitrev7(i) mod Q, centred.
  task automatic buildZetas();
    longint v;
    int e;
    for (int i = 0; i < 128; i++) begin
      e = 0;
      for (int b = 0; b < 7; b++) e = e | (((i >> b) & 1) << (6 - b));
      v = 2285;
      for (int n = 0; n < e; n++) v = (v * 17) % 3329;
      if (v > 1664) v = v - 3329;
      zetaTab[i] = int'(v);
    end
  endtask

  // Forward transform, used only to produce NTT-domain inputs.
  task automatic nttRef();
    int k;
    int t;
    int zeta;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        zeta = zetaTab[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = fqmulRef(zeta, modelIn[j + len]);
          modelIn[j + len] = wrap16(modelIn[j] - t);
          modelIn[j]       = wrap16(modelIn[j] + t);
        end
      end
    for (int i = 0; i < 256; i++) modelIn[i] = barrettRef(modelIn[i]);
  endtask

  // Reference inverse transform of modelIn into modelOut.
  task automatic computeModel();
    int m [256];
    int k;
    int t;
    int zeta;
    for (int i = 0; i < 256; i++) m[i] = modelIn[i];
    k = 127;
    for (int len = 2; len <= 128; len = len << 1)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        zeta = zetaTab[k];
        k--;
        for (int j = st; j < st + len; j++) begin
          t = m[j];
          m[j]       = barrettRef(wrap16(t + m[j + len]));
          m[j + len] = fqmulRef(zeta, wrap16(m[j + len] - t));
        end
      end
    for (int i = 0; i < 256; i++) modelOut[i] = fqmulRef(m[i], 1441);
  endtask

  task automatic randomInput();
    for (int i = 0; i < 256; i++) modelIn[i] = int'($urandom_range(0, 6656)) - 3328;
  endtask

  task automatic report(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (done !== 1'b1 && cycles < 1500);
  endtask

  task automatic applyStimulus(output int latency);
    for (int i = 0; i < 256; i++) rIn[i] = 16'(modelIn[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(latency);
  endtask

  task automatic checkOutput(input string name, input int latency);
    int nm;
    report({name, " latency"}, latency, 1153);
    nm = countMismatch();
    if (nm != 0)
      for (int i = 0; i < 256; i++)
        if (int'($signed(rOut[i])) != modelOut[i]) begin
          $display("[TB]   %s first differing index %0d dut=%0d model=%0d",
                   name, i, $signed(rOut[i]), modelOut[i]);
          break;
        end
    report({name, " coeff mismatches"}, nm, 0);
    report({name, " out of range"}, countOutOfRange(), 0);
    @(posedge clk);
    #1;
    report({name, " done width"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    int dc;
    int at;
    int nz;
    int resetPoints [2];

    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rIn[i] = '0;
    buildZetas();

    // Reset state
    repeat (3) @(negedge clk);
    report("reset done", int'(done), 0);
    report("reset r_out nonzero", countNonZero(), 0);
    rst = 1'b0;

    // Table of vectors: kind 0 zero, 1 ntt(delta), 2 constant, 3 alternating, 4 random
    tvTable[0] = '{0, 0, 0, 1};
    tvTable[1] = '{1, 0, 2285, 1};
    tvTable[2] = '{2, 3328, -1, 0};
    tvTable[3] = '{2, -3328, -1, 0};
    tvTable[4] = '{3, 3328, -1, 0};
    tvTable[5] = '{2, 1, -1, 0};
    tvTable[6] = '{4, 0, -1, 0};

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 256; i++) begin
        case (tvTable[t].kind)
          1:       modelIn[i] = (i == 0) ? 1 : 0;
          2:       modelIn[i] = tvTable[t].param;
          3:       modelIn[i] = (i % 2 == 0) ? tvTable[t].param : -tvTable[t].param;
          4:       modelIn[i] = int'($urandom_range(0, 6656)) - 3328;
          default: modelIn[i] = 0;
        endcase
      end
      if (tvTable[t].kind == 1) nttRef();
      computeModel();
      applyStimulus(lat);
      checkOutput($sformatf("vec%0d", t), lat);
      if (tvTable[t].expR0Mod >= 0)
        report($sformatf("vec%0d r0 mod q", t), modq(int'($signed(rOut[0]))), tvTable[t].expR0Mod);
      if (tvTable[t].othersZero != 0) begin
        nz = 0;
        for (int i = 1; i < 256; i++) if (modq(int'($signed(rOut[i]))) != 0) nz++;
        report($sformatf("vec%0d others nonzero mod q", t), nz, 0);
      end
    end

    // Randomised vectors against the model
    for (int n = 0; n < 20; n++) begin
      randomInput();
      computeModel();
      applyStimulus(lat);
      checkOutput($sformatf("rand%0d", n), lat);
    end

    // Reset during COMP and during SCALE, with start held high under reset
    resetPoints = '{600, 1000};
    for (int p = 0; p < 2; p++) begin
      randomInput();
      for (int i = 0; i < 256; i++) rIn[i] = 16'(modelIn[i]);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (resetPoints[p]) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      #1;
      report($sformatf("midreset%0d done", p), int'(done), 0);
      report($sformatf("midreset%0d r_out nonzero", p), countNonZero(), 0);
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      dc = 0;
      for (int c = 0; c < 1300; c++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) dc++;
      end
      report($sformatf("midreset%0d done pulses", p), dc, 0);
      report($sformatf("midreset%0d r_out after", p), countNonZero(), 0);
    end

    // start toggled randomly while busy, inputs scrambled after capture
    randomInput();
    computeModel();
    for (int i = 0; i < 256; i++) rIn[i] = 16'(modelIn[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'($urandom_range(0, 1));
    dc = 0;
    at = -1;
    for (int c = 1; c <= 1300; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dc++;
        at = c;
      end
      start = (c < 1140) ? 1'($urandom_range(0, 1)) : 1'b0;
      rIn[$urandom_range(0, 255)] = 16'($urandom_range(0, 6656) - 3328);
    end
    report("toggle done pulses", dc, 1);
    report("toggle done edge", at, 1153);
    report("toggle coeff mismatches", countMismatch(), 0);

    // start held high: back-to-back runs, each capturing its own input
    randomInput();
    computeModel();
    for (int i = 0; i < 256; i++) rIn[i] = 16'(modelIn[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      waitDone(lat);
      report($sformatf("held%0d interval", r), lat, (r == 0) ? 1153 : 1154);
      report($sformatf("held%0d coeff mismatches", r), countMismatch(), 0);
      if (r < 2) begin
        randomInput();
        computeModel();
        for (int i = 0; i < 256; i++) rIn[i] = 16'(modelIn[i]);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    report("held final done width", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
